uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_2ff.sv | 24 ++
 rtl/uart_rx_core.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_OVERSAMPLE    = 8;
    localparam int PARITY_SENSE_EVEN = 0;
    localparam int PARITY_SENSE_ODD  = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start detect, mid-bit sampling, stop/break handling.
// Define UART_RX_PARITY_EN to receive one parity bit after the data bits.
//
// state  | meaning
// IDLE   | waiting; armed once the line is sampled high, low sample then starts a frame
// START  | counting to mid start bit, re-check for a false start
// DATA   | sampling DATA_BITS bits LSB first, one per OVERSAMPLE ticks
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then publishing the word
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_ODD = PARITY_SENSE_EVEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 2 ||
        PARITY_ODD < PARITY_SENSE_EVEN || PARITY_ODD > PARITY_SENSE_ODD) begin : g_bad_params
        $error("uart_rx_core: unsupported parameter set");
    end

    rx_state_e            state_q;
    logic                 armed_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
    logic                 perr_q;
    logic                 perr_d;

    assign perr_d = ((^shift_q) ^ par_q) != (PARITY_ODD != 0);
`endif

    uart_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (rx_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (armed_q && !rx_s) begin
                            state_q <= ST_START;
                            busy_q  <= 1'b1;
                            tick_q  <= '0;
                            armed_q <= 1'b0;
                        end else if (rx_s) begin
                            armed_q <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            if (rx_s) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                armed_q <= 1'b1;
                            end else begin
                                state_q <= ST_DATA;
                                bit_q   <= '0;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            shift_q <= shift_d;
                            if (bit_q == BIT_LAST) begin
                                bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                                state_q <= ST_PARITY;
`else
                                state_q <= ST_STOP;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    ST_PARITY: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            par_q   <= rx_s;
                            state_q <= ST_STOP;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            ferr_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= perr_d;
`endif
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            // A break leaves the block disarmed until the line returns high.
                            armed_q <= rx_s;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tick_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame-level reference queue, randomized gating and data.
// Parity cases are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int OS   = 8;
    localparam int DB   = 8;
    localparam int PODD = PARITY_SENSE_EVEN;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          rx_tick = 1'b0;
    logic          rx_in   = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx_core #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_tick    (rx_tick),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_e;
    int     n_valid    = 0;
    int     busy_clks  = 0;
    bit     gated      = 1'b0;
    logic   prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset && rx_valid) begin
            n_valid++;
            chk("valid_one_clk", 32'(prev_valid), 32'd0);
            chk("busy_low_at_valid", 32'(busy), 32'd0);
            chk("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(mon_e.data));
                chk("frame_err", 32'(frame_err), 32'(mon_e.ferr));
                chk("parity_err", 32'(parity_err), 32'(mon_e.perr));
            end
        end
        prev_valid = rx_valid;
        if (busy) busy_clks++;
    end

    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    // One rx_tick strobe; in gated mode at most one tick per three clocks plus random stalls.
    task automatic one_tick();
        int gap;
        gap = 0;
        if (gated) begin
            gap = 2;
            if ($urandom_range(0, 3) == 0) gap += $urandom_range(1, 6);
        end
        rx_tick = 1'b0;
        repeat (gap) @(negedge clk);
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
    endtask

    task automatic line(input logic v, input int n);
        rx_in = v;
        repeat (n) one_tick();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
        frame_t e;
        e.data = d;
        e.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
        e.perr = ((^d) ^ par) != (PODD != 0);
`else
        e.perr = 1'b0;
        if (par) e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        line(1'b0, OS);
        for (int i = 0; i < DB; i++) line(d[i], OS);
`ifdef UART_RX_PARITY_EN
        line(par, OS);
`endif
        line(stop, OS);
    endtask

    int            nv0;
    logic [DB-1:0] rd;
    logic          rstop;
    logic          rpar;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_parity_err", 32'(parity_err), 32'd0);

        // Line held low out of reset must not be taken as a start bit.
        rx_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        line(1'b0, 12);
        chk("no_arm_after_reset", 32'(busy), 32'd0);
        line(1'b1, OS);

        send_frame(8'hA5, 1'b1, good_par(8'hA5));
        line(1'b1, 2 * OS);
        chk("a5_data_held", 32'(rx_data), 32'hA5);

        // Two-tick glitch: false start, busy for exactly half a bit.
        nv0 = n_valid;
        busy_clks = 0;
        line(1'b0, 2);
        line(1'b1, 3 * OS);
        chk("glitch_busy_clks", 32'(busy_clks), 32'(OS / 2));
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(n_valid - nv0), 32'd0);

        // Break: low stop bit, then the line stays low.
        nv0 = n_valid;
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        line(1'b0, 40);
        chk("break_one_valid", 32'(n_valid - nv0), 32'd1);
        chk("break_no_restart", 32'(busy), 32'd0);
        line(1'b1, 2 * OS);
        send_frame(8'h96, 1'b1, good_par(8'h96));
        line(1'b1, 2 * OS);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        line(1'b1, 2 * OS);
        chk("par07_bad", 32'(parity_err), 32'd1);
        send_frame(8'h07, 1'b1, 1'b1);
        line(1'b1, 2 * OS);
        chk("par07_good", 32'(parity_err), 32'd0);
`endif

        // Reset during data bit 4 of 0xFF abandons that frame.
        nv0 = n_valid;
        line(1'b0, OS);
        for (int i = 0; i < 4; i++) line(1'b1, OS);
        line(1'b1, OS / 2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_rx_data", 32'(rx_data), 32'd0);
        rx_in = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        line(1'b1, OS);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        line(1'b1, 2 * OS);
        chk("midreset_one_valid", 32'(n_valid - nv0), 32'd1);
        chk("midreset_data", 32'(rx_data), 32'h81);

        gated = 1'b1;
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        line(1'b1, 2 * OS);
        chk("gated_5a", 32'(rx_data), 32'h5A);

        for (int k = 0; k < 8; k++) begin
            rd    = DB'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            rpar  = ($urandom_range(0, 3) == 0) ? ~good_par(rd) : good_par(rd);
            gated = bit'($urandom_range(0, 1));
            send_frame(rd, rstop, rpar);
            line(1'b1, 2 * OS);
        end

        repeat (20) @(negedge clk);
        chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
